// File: rtl/ne16_normquant_multiplier_pipe.sv
// Multi-lane normalisation multiplier: signed accumulator x signed/unsigned factor, exact products,
// behind an elastic valid/ready pipeline of PIPE stages with bubble collapse and synchronous flush.
module ne16_normquant_multiplier_pipe #(
  parameter int NMS    = 8,
  parameter int ACC    = 32,
  parameter int NLANES = 4,
  parameter int PIPE   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         signed_mode_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NLANES-1:0]            lane_en_i,
  input  logic [NLANES*NMS-1:0]        norm_mult_i,
  input  logic [NLANES*ACC-1:0]        accumulator_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NLANES*(NMS+ACC+1)-1:0] product_o
);

  localparam int PW = NMS + ACC + 1;
  localparam int DW = NLANES * PW;

  logic [DW-1:0] prod_in;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic signed [NMS:0]    fac;
    logic signed [ACC-1:0]  acc;
    logic signed [PW-1:0]   prod;

    // The extra factor bit carries the sign only in signed mode, so unsigned factors stay positive.
    assign fac  = {signed_mode_i & norm_mult_i[k*NMS+NMS-1], norm_mult_i[k*NMS +: NMS]};
    assign acc  = accumulator_i[k*ACC +: ACC];
    assign prod = PW'(fac) * PW'(acc);
    assign prod_in[k*PW +: PW] = lane_en_i[k] ? prod : '0;
  end

  if (PIPE == 0) begin : g_comb
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign product_o   = prod_in;
  end else begin : g_pipe
    logic [PIPE-1:0] valid_q;
    logic [DW-1:0]   data_q  [PIPE];
    logic [PIPE-1:0] ready;
    logic [PIPE-1:0] stage_v;
    logic [DW-1:0]   stage_d [PIPE];

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
      if (s == 0) begin : g_first
        assign stage_v[s] = in_valid_i;
        assign stage_d[s] = prod_in;
      end else begin : g_next
        assign stage_v[s] = valid_q[s-1];
        assign stage_d[s] = data_q[s-1];
      end
      // Unrolled ready chain: a stage can move if the sink is ready or any later stage has a hole.
      assign ready[s] = out_ready_i | ~(&valid_q[PIPE-1:s]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
        for (int s = 0; s < PIPE; s++) data_q[s] <= '0;
      end else if (clear_i) begin
        valid_q <= '0;
        for (int s = 0; s < PIPE; s++) data_q[s] <= '0;
      end else begin
        for (int s = 0; s < PIPE; s++) begin
          if (ready[s]) begin
            valid_q[s] <= stage_v[s];
            data_q[s]  <= stage_v[s] ? stage_d[s] : '0;
          end
        end
      end
    end

    assign in_ready_o  = ready[0] & ~clear_i;
    assign out_valid_o = valid_q[PIPE-1];
    assign product_o   = data_q[PIPE-1];
  end

endmodule

// File: tb/tb_ne16_normquant_multiplier_pipe.sv
// Directed bench: one DUT instance per PIPE depth 0..4 sharing operand inputs, own handshake lines.
module tb_ne16_normquant_multiplier_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         signed_mode = 1'b0;
  logic [3:0]   lane_en = '0;
  logic [31:0]  norm_mult = '0;
  logic [127:0] accumulator = '0;
  logic [4:0]   in_vld = '0;
  logic [4:0]   out_rdy = '1;
  logic [4:0]   clr = '0;
  logic [4:0]   in_rdy;
  logic [4:0]   out_vld;
  logic [163:0] prod [5];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    ne16_normquant_multiplier_pipe #(.NMS(8), .ACC(32), .NLANES(4), .PIPE(g)) u_dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clr[g]), .signed_mode_i(signed_mode),
      .in_valid_i(in_vld[g]), .in_ready_o(in_rdy[g]), .lane_en_i(lane_en),
      .norm_mult_i(norm_mult), .accumulator_i(accumulator),
      .out_valid_o(out_vld[g]), .out_ready_i(out_rdy[g]), .product_o(prod[g])
    );
  end

  task automatic check(input string tag, input logic [163:0] got, input logic [163:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [163:0] bexp(input int i);
    return 164'((i + 1) * (100 + i));
  endfunction

  task automatic set_beat(input int i);
    signed_mode = 1'b1;
    lane_en     = 4'b0001;
    norm_mult   = {24'b0, 8'(i + 1)};
    accumulator = {96'b0, 32'(100 + i)};
  endtask

  // PIPE=1 single beat; the mode is flipped after the handshake to prove it travels with the data.
  task automatic beat1(input string tag, input logic sm, input logic [3:0] en,
                       input logic [31:0] nm, input logic [127:0] ac, input logic [163:0] exp);
    @(negedge clk);
    signed_mode = sm; lane_en = en; norm_mult = nm; accumulator = ac; in_vld[1] = 1'b1;
    #1;
    check({tag, "_rdy"}, in_rdy[1], 1);
    check({tag, "_idle"}, out_vld[1], 0);
    @(negedge clk);
    in_vld[1] = 1'b0; signed_mode = ~sm; accumulator = '0;
    #1;
    check({tag, "_vld"}, out_vld[1], 1);
    check({tag, "_prod"}, prod[1], exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sent, recv, occ, cyc;
    logic acc_now, emit_now, stalled;
    logic [163:0] held;

    #2;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rst_vld%0d", g), out_vld[g], 0);
      check($sformatf("rst_prod%0d", g), prod[g], 0);
      check($sformatf("rst_rdy%0d", g), in_rdy[g], 1);
    end
    @(negedge clk);
    rst = 1'b0;

    // PIPE=0 is a pure combinational pass-through
    signed_mode = 1'b1; lane_en = 4'b0001; norm_mult = 32'hFF; accumulator = 128'h5;
    in_vld[0] = 1'b1; out_rdy[0] = 1'b0;
    #1;
    check("p0_vld", out_vld[0], 1);
    check("p0_rdy", in_rdy[0], 0);
    check("p0_prod", prod[0], {123'b0, 41'h1FF_FFFF_FFFB});
    in_vld[0] = 1'b0; out_rdy[0] = 1'b1;

    beat1("s_neg", 1'b1, 4'b0001, 32'h0000_00FF, 128'h5, {123'b0, 41'h1FF_FFFF_FFFB});
    beat1("u_pos", 1'b0, 4'b0001, 32'h0000_00FF, 128'h5, 164'd1275);
    beat1("s_ext", 1'b1, 4'b0001, 32'h0000_0080, {96'b0, 32'h8000_0000}, {123'b0, 41'h040_0000_0000});
    beat1("u_ext", 1'b0, 4'b0001, 32'h0000_0080, {96'b0, 32'h8000_0000}, {123'b0, 41'h1C0_0000_0000});
    beat1("lane_en", 1'b1, 4'b0101, {4{8'h03}}, {4{32'd7}}, {41'd0, 41'd21, 41'd0, 41'd21});
    beat1("s_mix", 1'b1, 4'b1111, {8'hFE, 8'h7F, 8'h00, 8'h81},
          {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0002},
          {41'd6, 41'h1FF_FFFF_FF81, 41'd0, 41'h1FF_FFFF_FF02});
    beat1("u_mix", 1'b0, 4'b1111, {8'hFE, 8'h7F, 8'h00, 8'h81},
          {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0002},
          {41'h1FF_FFFF_FD06, 41'h1FF_FFFF_FF81, 41'd0, 41'h102});

    // PIPE=3 streaming with out_ready pattern 1,0,0 repeating
    sent = 0; recv = 0; occ = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (recv < 10 && cyc < 200) begin
      @(negedge clk);
      out_rdy[3] = (cyc % 3 == 0);
      in_vld[3]  = (sent < 10);
      set_beat(sent);
      #1;
      if (stalled) check("bp_stable", prod[3], held);
      check("bp_rdy", in_rdy[3], (out_rdy[3] || occ < 3));
      acc_now  = in_vld[3] && in_rdy[3];
      emit_now = out_vld[3] && out_rdy[3];
      if (emit_now) begin
        check($sformatf("bp_data%0d", recv), prod[3], bexp(recv));
        recv++;
      end
      stalled = out_vld[3] && !out_rdy[3];
      held    = prod[3];
      if (acc_now) sent++;
      occ = occ + int'(acc_now) - int'(emit_now);
      cyc++;
    end
    in_vld[3] = 1'b0; out_rdy[3] = 1'b1;
    check("bp_count", 164'(recv), 164'd10);
    @(negedge clk);
    #1;
    check("bp_drained", out_vld[3], 0);

    // PIPE=2 flush with two beats in flight
    out_rdy[2] = 1'b0;
    @(negedge clk); set_beat(20); in_vld[2] = 1'b1;
    @(negedge clk); set_beat(21);
    @(negedge clk); set_beat(22); clr[2] = 1'b1;
    #1;
    check("clr_rdy", in_rdy[2], 0);
    check("clr_full", out_vld[2], 1);
    check("clr_head", prod[2], bexp(20));
    @(negedge clk); clr[2] = 1'b0; out_rdy[2] = 1'b1; set_beat(23);
    #1;
    check("clr_vld", out_vld[2], 0);
    check("clr_prod", prod[2], 0);
    check("clr_rdy2", in_rdy[2], 1);
    @(negedge clk); in_vld[2] = 1'b0;
    #1;
    check("clr_lat1", out_vld[2], 0);
    @(negedge clk);
    #1;
    check("clr_lat2", out_vld[2], 1);
    check("clr_next", prod[2], bexp(23));

    // PIPE=4 async reset with all stages full
    out_rdy[4] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_beat(30 + i); in_vld[4] = 1'b1;
    end
    @(negedge clk); in_vld[4] = 1'b0;
    #1;
    check("ar_full_vld", out_vld[4], 1);
    check("ar_full_rdy", in_rdy[4], 0);
    check("ar_full_prod", prod[4], bexp(30));
    #1 rst = 1'b1;
    #1;
    check("ar_vld", out_vld[4], 0);
    check("ar_prod", prod[4], 0);
    check("ar_rdy", in_rdy[4], 1);
    #1 rst = 1'b0;
    out_rdy[4] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("ar_quiet%0d", i), out_vld[4], 0);
    end
    @(negedge clk); set_beat(40); in_vld[4] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); in_vld[4] = 1'b0;
      #1;
      check($sformatf("ar_lat%0d", i), out_vld[4], 0);
    end
    @(negedge clk);
    #1;
    check("ar_new_vld", out_vld[4], 1);
    check("ar_new_prod", prod[4], bexp(40));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ne16_normquant_multiplier_pipe.md
Name: ne16_normquant_multiplier_pipe

Overview:
- Multi-lane, elastic-pipelined normalisation multiplier for the NE16 normquant path.
- Multiplies each lane's signed accumulator by a per-lane normalisation factor. The factor is interpreted as signed or unsigned per a mode bit.
- Produces full-precision products with no truncation, behind a valid/ready handshake with configurable pipeline depth.
- Sits between accumulator readout and the normquant shift/clip stage. Replaces the single-lane, fixed-enable multiplier.

Parameters:
- NMS, ne16_package::NORM_MULT_SIZE, normalisation factor width in bits (magnitude field).
- ACC, ne16_package::NE16_ACCUM_SIZE, accumulator width in bits (signed).
- NLANES, 4, number of parallel lanes.
- PIPE, 1, number of register stages (0..4). 0 means combinational pass-through.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous flush of all pipeline stages.
- signed_mode_i  in  1  1: norm_mult is two's-complement NMS bits; 0: unsigned NMS bits.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept the input beat.
- lane_en_i  in  NLANES  per-lane enable; disabled lanes produce product 0.
- norm_mult_i  in  NLANES*NMS  per-lane factor; lane k occupies bits [k*NMS +: NMS].
- accumulator_i  in  NLANES*ACC  per-lane signed accumulator; lane k at [k*ACC +: ACC].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts the output beat.
- product_o  out  NLANES*(NMS+ACC+1)  per-lane signed product; lane k at [k*(NMS+ACC+1) +: NMS+ACC+1].

Behaviour:
- Reset, rst_i high, asynchronous: all stage valid bits 0 and all stage data registers 0. Therefore out_valid_o=0 and product_o=0. in_ready_o=1 once the reset is applied.
- Operand extension:
  - The factor is extended to NMS+1 bits: sign-extended if signed_mode_i=1, zero-extended otherwise.
  - The accumulator is signed ACC bits.
  - The product is signed NMS+ACC+1 bits, exact, with no overflow possible.
- Lane enable: if lane_en_i[k]=0, the lane-k product is forced to 0 at stage input.
- signed_mode_i and lane_en_i are sampled together with the beat on handshake. They travel with the data, so a mode change never affects beats already in flight.
- Handshake:
  - An input transfer occurs when in_valid_i & in_ready_o.
  - An output transfer occurs when out_valid_o & out_ready_i.
  - Once out_valid_o=1, product_o holds stable until the transfer occurs.
- PIPE=0:
  - out_valid_o=in_valid_i, in_ready_o=out_ready_i, product_o combinational.
  - clear_i has no effect.
- PIPE>=1:
  - Chain of PIPE stages. Stage s holds valid_q[s] and data_q[s].
  - Stage s is ready when ~valid_q[s] | ready[s+1]. The last stage's ready[s+1] is out_ready_i.
  - in_ready_o = ready of stage 0.
  - On a stage-ready cycle, stage s loads valid/data from the previous stage (or from the input for stage 0). Otherwise it holds.
  - The multiply is computed at stage-0 input. Later stages only retime.
- Latency: exactly PIPE cycles from input transfer to out_valid_o when out_ready_i=1 throughout.
- Throughput: one beat per cycle under no backpressure.
- Bubbles collapse: a stalled output does not block filling of empty upstream stages.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.
- Backpressure with a full pipe: in_ready_o=0 in the same cycle, combinationally, via the ready chain.
- clear_i (PIPE>=1):
  - Next cycle, all valid_q=0 and all data_q=0. This discards in-flight beats.
  - An input beat presented in the same cycle as clear_i is not accepted. in_ready_o is forced to 0 while clear_i=1.
- Simultaneous events:
  - rst_i dominates clear_i, and clear_i dominates load/hold.
  - In a stage, a simultaneous output transfer and input load are both performed (pass-through at full rate).
- Reset mid-operation: all in-flight beats are lost and outputs return immediately to reset values. No partial beat appears after deassertion.

Test Plan:
- Reset + single beat: PIPE=1, NMS=8, ACC=32, signed_mode=1, lane0 factor 0xFF (-1), acc 0x0000_0005 -> after 1 cycle out_valid_o=1, lane0 product = -5, i.e. all-ones pattern ending in ...FFFB across 41 bits.
- Unsigned mode: same operands, signed_mode=0 -> lane0 product = 255*5 = 1275. Extreme case: factor 0x80 with acc 0x8000_0000 gives signed +2^38 and unsigned -2^38, checked exactly.
- Lane enable: lane_en=4'b0101 with all lanes factor 3, acc 7 -> products {0,21,0,21} for lanes 3..0.
- Backpressure: PIPE=3, stream 10 beats with out_ready_i toggling 1,0,0,1,... -> all 10 products emerge in order, none lost or duplicated. in_ready_o=0 only when all 3 stages are valid and out_ready_i=0. product_o stays stable while stalled.
- Clear mid-stream: PIPE=2, two beats in flight, assert clear_i one cycle with in_valid_i=1 -> in_ready_o=0 that cycle, next cycle out_valid_o=0 and product_o=0, and the next accepted beat emerges after 2 cycles.
- Async reset mid-flight: PIPE=4, four valid stages, pulse rst_i between clock edges -> out_valid_o=0 and product_o=0 immediately, no beat emitted after release until a new input.
